// File: rtl/jtkcpu_pcseq.sv
`default_nettype none
// ============================================================================
//  Module   : jtkcpu_pcseq
//  Purpose  : KCPU program-counter sequencer (inc, relative branch with
//             one-shot lock, jump/load, byte pull) plus interrupt-vector fetch.
//  Option   : JTKCPU_BRTRACE_EN adds br_src/br_dst branch-trace outputs.
//  Revision : 1.0  initial release
// ============================================================================
module jtkcpu_pcseq #(
   parameter int            AW       = 16,
   parameter int            VW       = 3,
   parameter logic [AW-1:0] VEC_BASE = {AW{1'b1}} ^ AW'(15),
   parameter logic [AW-1:0] RST_PC   = '0
) (
   input  logic          rst,
   input  logic          clk,
   input  logic          cen,
   input  logic          inc,
   input  logic          inc_hold,
   input  logic          br8,
   input  logic          br16,
   input  logic          cond,
   input  logic [15:0]   mdata,
   input  logic          jmp,
   input  logic [AW-1:0] jmp_addr,
   input  logic          ld,
   input  logic          pul_en,
   input  logic [1:0]    pul_idx,
   input  logic          vec_go,
   input  logic [VW-1:0] vec_num,
   output logic [AW-1:0] vec_addr,
   output logic          vec_rd,
   input  logic          vec_ack,
   input  logic [7:0]    vec_data,
   output logic          busy,
   output logic          taken,
`ifdef JTKCPU_BRTRACE_EN
   output logic [AW-1:0] br_src,
   output logic [AW-1:0] br_dst,
`endif
   output logic [AW-1:0] pc
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RDHI = 2'd1,
      ST_RDLO = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t        r_st, w_st_nxt;
   logic [AW-1:0] r_pc, w_pc_nxt;
   logic [AW-1:0] r_vaddr;
   logic          r_vrd;
   logic [7:0]    r_hi, r_lo;
   logic          r_lock, w_lock_nxt;
   logic          r_taken;
   logic          w_busy, w_inc, w_brq, w_br, w_ack, w_trk;
   logic [AW-1:0] w_off8, w_off16, w_vbase;

   assign w_busy   = (r_st != ST_IDLE);
   assign w_ack    = vec_ack && r_vrd;
   assign w_off8   = AW'($signed(mdata[7:0]));
   assign w_off16  = AW'($signed(mdata));
   assign w_vbase  = VEC_BASE + {{(AW-VW-1){1'b0}}, vec_num, 1'b0};

   // A branch only counts as taken when it is the update actually selected
   assign w_inc    = inc && !inc_hold && !w_busy;
   assign w_brq    = (br8 || br16) && cond && !r_lock;
   assign w_br     = w_brq && !w_busy && !w_inc;
   assign w_trk    = (r_st == ST_DONE) || (!w_busy && !w_inc && (w_br || jmp || ld));

   assign pc       = r_pc;
   assign vec_addr = r_vaddr;
   assign vec_rd   = r_vrd;
   assign busy     = w_busy;
   assign taken    = r_taken;

   always_comb begin
      w_st_nxt = r_st;
      case (r_st)
         ST_IDLE: if (vec_go) w_st_nxt = ST_RDHI;
         ST_RDHI: if (w_ack)  w_st_nxt = ST_RDLO;
         ST_RDLO: if (w_ack)  w_st_nxt = ST_DONE;
         ST_DONE:             w_st_nxt = ST_IDLE;
         default:             w_st_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_pc_nxt = r_pc;
      if (r_st == ST_DONE)  w_pc_nxt = AW'({r_hi, r_lo});
      else if (w_busy)      w_pc_nxt = r_pc;
      else if (w_inc)       w_pc_nxt = r_pc + AW'(1);
      else if (w_br)        w_pc_nxt = r_pc + (br8 ? w_off8 : w_off16);
      else if (jmp)         w_pc_nxt = jmp_addr;
      else if (ld)          w_pc_nxt = AW'(mdata);
      // Byte pull lands on top of whatever the priority chain chose
      if (!w_busy && pul_en) begin
         for (int i = 0; i < AW/8; i++) begin
            if (pul_idx == 2'(i)) w_pc_nxt[8*i +: 8] = mdata[7:0];
         end
      end
   end

   always_comb begin
      w_lock_nxt = r_lock;
      if (!br8 && !br16) w_lock_nxt = 1'b0;
      else if (w_br)     w_lock_nxt = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_st    <= ST_IDLE;
         r_pc    <= RST_PC;
         r_vaddr <= '0;
         r_vrd   <= 1'b0;
         r_hi    <= 8'd0;
         r_lo    <= 8'd0;
         r_lock  <= 1'b0;
         r_taken <= 1'b0;
      end else if (cen) begin
         r_st    <= w_st_nxt;
         r_pc    <= w_pc_nxt;
         r_lock  <= w_lock_nxt;
         r_taken <= w_br;
         case (r_st)
            ST_IDLE: if (vec_go) begin
               r_vaddr <= w_vbase;
               r_vrd   <= 1'b1;
            end
            ST_RDHI: if (w_ack) begin
               r_hi    <= vec_data;
               r_vaddr <= r_vaddr + AW'(1);
            end
            ST_RDLO: if (w_ack) begin
               r_lo    <= vec_data;
               r_vrd   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

`ifdef JTKCPU_BRTRACE_EN
   logic [AW-1:0] r_br_src, r_br_dst;

   assign br_src = r_br_src;
   assign br_dst = r_br_dst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_br_src <= '0;
         r_br_dst <= '0;
      end else if (cen && w_trk) begin
         r_br_src <= r_pc;
         r_br_dst <= w_pc_nxt;
      end
   end
`else
   logic w_unused_trk;
   assign w_unused_trk = w_trk;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jtkcpu_pcseq.sv
`default_nettype none
// Bench for jtkcpu_pcseq: AW=16 and AW=24 instances share stimulus; a
// behavioural model fills a scoreboard queue that a monitor drains each cycle.
module tb_jtkcpu_pcseq;

   logic        clk = 1'b0, rst = 1'b1, cen = 1'b0;
   logic        inc = 0, inc_hold = 0, br8 = 0, br16 = 0, cond = 0;
   logic [15:0] mdata = 0;
   logic        jmp = 0, ld = 0, pul_en = 0, vec_go = 0, vec_ack = 0;
   logic [23:0] jmp_addr = 0;
   logic [1:0]  pul_idx = 0;
   logic [2:0]  vec_num = 0;
   logic [7:0]  vec_data = 0;

   logic [15:0] pc16, va16;
   logic [23:0] pc24, va24;
   logic        vrd16, vrd24, bsy16, bsy24, tk16, tk24;

   int n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   jtkcpu_pcseq #(.AW(16)) u_dut16 (
      .rst(rst), .clk(clk), .cen(cen), .inc(inc), .inc_hold(inc_hold),
      .br8(br8), .br16(br16), .cond(cond), .mdata(mdata), .jmp(jmp),
      .jmp_addr(jmp_addr[15:0]), .ld(ld), .pul_en(pul_en), .pul_idx(pul_idx),
      .vec_go(vec_go), .vec_num(vec_num), .vec_addr(va16), .vec_rd(vrd16),
      .vec_ack(vec_ack), .vec_data(vec_data), .busy(bsy16), .taken(tk16),
      .pc(pc16));

   jtkcpu_pcseq #(.AW(24)) u_dut24 (
      .rst(rst), .clk(clk), .cen(cen), .inc(inc), .inc_hold(inc_hold),
      .br8(br8), .br16(br16), .cond(cond), .mdata(mdata), .jmp(jmp),
      .jmp_addr(jmp_addr), .ld(ld), .pul_en(pul_en), .pul_idx(pul_idx),
      .vec_go(vec_go), .vec_num(vec_num), .vec_addr(va24), .vec_rd(vrd24),
      .vec_ack(vec_ack), .vec_data(vec_data), .busy(bsy24), .taken(tk24),
      .pc(pc24));

   typedef struct {
      logic [23:0] pc[2];
      logic [23:0] va[2];
      logic        tk, bsy, vrd;
   } exp_t;

   exp_t q[$];

   // Reference model state, one entry per instance width
   longint m_pc[2], m_va[2];
   bit     m_lock, m_vrd, m_tk;
   int     m_ph;              // 0 idle, 1 high byte, 2 low byte, 3 load pc
   bit [7:0] m_hi, m_lo;

   function automatic int wid(int k); return k ? 24 : 16; endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin m_pc[k] = 0; m_va[k] = 0; end
      m_lock = 0; m_vrd = 0; m_tk = 0; m_ph = 0; m_hi = 0; m_lo = 0;
   endtask

   task automatic push_exp();
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         e.pc[k] = 24'(m_pc[k]);
         e.va[k] = 24'(m_va[k]);
      end
      e.tk = m_tk; e.bsy = (m_ph != 0); e.vrd = m_vrd;
      q.push_back(e);
   endtask

   task automatic model_step();
      bit bsy, do_inc, do_br, ack;
      int nph;
      if (!cen) return;
      bsy    = (m_ph != 0);
      do_inc = inc && !inc_hold && !bsy;
      do_br  = (br8 || br16) && cond && !m_lock && !bsy && !do_inc;
      ack    = vec_ack && m_vrd;
      nph    = m_ph;
      for (int k = 0; k < 2; k++) begin
         longint mask = (longint'(1) << wid(k)) - 1;
         longint n = m_pc[k];
         if (m_ph == 3) n = {m_hi, m_lo};
         else if (!bsy) begin
            if (do_inc)     n = n + 1;
            else if (do_br) n = n + (br8 ? longint'($signed(mdata[7:0]))
                                         : longint'($signed(mdata)));
            else if (jmp)   n = jmp_addr;
            else if (ld)    n = mdata;
            n = n & mask;
            if (pul_en && int'(pul_idx) < wid(k) / 8) begin
               n = (n & ~(longint'(255) << (8 * pul_idx)))
                   | (longint'(mdata[7:0]) << (8 * pul_idx));
            end
         end
         m_pc[k] = n & mask;
         if (m_ph == 0 && vec_go) m_va[k] = (mask - 15 + 2 * vec_num) & mask;
         if (m_ph == 1 && ack)    m_va[k] = (m_va[k] + 1) & mask;
      end
      case (m_ph)
         0: if (vec_go) begin nph = 1; m_vrd = 1; end
         1: if (ack) begin nph = 2; m_hi = vec_data; end
         2: if (ack) begin nph = 3; m_lo = vec_data; m_vrd = 0; end
         default: nph = 0;
      endcase
      m_ph = nph;
      if (!br8 && !br16) m_lock = 0;
      else if (do_br)    m_lock = 1;
      m_tk = do_br;
   endtask

   // Inputs are set just after a negedge; the model consumes them, then we
   // wait past the posedge to the next negedge.
   task automatic tick();
      model_step();
      push_exp();
      @(negedge clk);
   endtask

   task automatic clear_in();
      cen = 1; inc = 0; inc_hold = 0; br8 = 0; br16 = 0; cond = 0;
      jmp = 0; ld = 0; pul_en = 0; vec_go = 0; vec_ack = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      model_reset();
      push_exp();
      @(negedge clk);
      rst = 0;
   endtask

   task automatic chk(string nm, logic [23:0] act, logic [23:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc16",   24'(pc16), e.pc[0]);
            chk("pc24",   pc24,      e.pc[1]);
            chk("vaddr16",24'(va16), e.va[0]);
            chk("vaddr24",va24,      e.va[1]);
            chk("taken16",24'(tk16), 24'(e.tk));
            chk("taken24",24'(tk24), 24'(e.tk));
            chk("busy16", 24'(bsy16),24'(e.bsy));
            chk("busy24", 24'(bsy24),24'(e.bsy));
            chk("vecrd16",24'(vrd16),24'(e.vrd));
            chk("vecrd24",24'(vrd24),24'(e.vrd));
         end
      end
   end

   task automatic ack_after(int dly, logic [7:0] d);
      for (int i = 0; i < dly; i++) begin vec_ack = 0; tick(); end
      vec_ack = 1; vec_data = d; tick();
      vec_ack = 0;
   endtask

   initial begin : driver
      model_reset();
      push_exp();
      @(negedge clk);
      rst = 0;
      clear_in();

      // increment, then suppressed increment
      inc = 1; repeat (3) tick();
      inc_hold = 1; tick();
      clear_in();

      // held short branch applies once, re-arms after release
      jmp = 1; jmp_addr = 24'h001000; tick(); jmp = 0;
      br8 = 1; cond = 1; mdata = 16'h00F0; repeat (4) tick();
      br8 = 0; tick();
      br8 = 1; tick(); tick();
      clear_in(); tick();

      // long branch with wrap, then condition false
      jmp = 1; jmp_addr = 24'h00FFF0; tick(); jmp = 0;
      br16 = 1; cond = 1; mdata = 16'h0020; tick();
      br16 = 0; tick();
      jmp = 1; tick(); jmp = 0;
      br16 = 1; cond = 0; tick(); tick();
      clear_in(); tick();

      // vector fetch with slow acks and a concurrent inc
      vec_go = 1; vec_num = 3; tick(); vec_go = 0; inc = 1;
      ack_after(2, 8'h12);
      ack_after(2, 8'h34);
      tick(); tick();
      clear_in();

      // byte pull, and lane 2 that only the wide instance has
      jmp = 1; jmp_addr = 24'h005678; tick(); jmp = 0;
      pul_en = 1; pul_idx = 1; mdata = 16'h00AB; tick(); pul_en = 0;
      ld = 1; mdata = 16'h1234; tick(); ld = 0;
      pul_en = 1; pul_idx = 2; mdata = 16'h007F; tick(); pul_en = 0;
      pul_en = 1; pul_idx = 3; mdata = 16'h0055; tick(); pul_en = 0;
      tick();

      // reset during the low-byte read, then a clean restart
      vec_go = 1; vec_num = 5; tick(); vec_go = 0;
      ack_after(0, 8'hA5);
      tick();
      do_reset();
      clear_in();
      vec_go = 1; vec_num = 0; tick(); vec_go = 0;
      ack_after(1, 8'hBE);
      ack_after(0, 8'hEF);
      tick(); tick();

      // randomized traffic
      for (int n = 0; n < 800; n++) begin
         if ($urandom % 200 == 0) begin
            do_reset();
         end else begin
            cen      = ($urandom % 5) != 0;
            inc      = ($urandom % 4) == 0;
            inc_hold = ($urandom % 4) == 0;
            br8      = ($urandom % 5) == 0;
            br16     = ($urandom % 6) == 0;
            cond     = $urandom % 2;
            mdata    = 16'($urandom);
            jmp      = ($urandom % 8) == 0;
            jmp_addr = 24'($urandom);
            ld       = ($urandom % 10) == 0;
            pul_en   = ($urandom % 8) == 0;
            pul_idx  = 2'($urandom);
            vec_go   = ($urandom % 12) == 0;
            vec_num  = 3'($urandom);
            vec_ack  = ($urandom % 3) == 0;
            vec_data = 8'($urandom);
            tick();
         end
      end
      clear_in();
      tick();
      @(posedge clk);
      #2;
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/jtkcpu_pcseq.md
Name: jtkcpu_pcseq

Overview:
Parametrised program-counter sequencer for the KCPU family. It is the successor of the PC logic inside the CPU control block, generalised to an AW-bit address space. It handles increment, 8/16-bit relative branches with a proper one-shot lock, absolute jumps/loads and byte-serial PC pull. It adds an autonomous interrupt-vector fetch FSM with a memory handshake. It sits between the microcode sequencer and the bus interface.

Parameters:
AW, 16, PC width; multiple of 8, range 16..24
VW, 3, vector index width
VEC_BASE, {AW{1'b1}}-15 (0xFFF0 at AW=16), vector table base address
RST_PC, 0, PC value after reset

Ports:
rst  in  1  asynchronous reset, active-high
clk  in  1  clock
cen  in  1  clock enable; all state advances only when high
inc  in  1  increment PC (ni/opd/post-increment request)
inc_hold  in  1  suppress inc (interrupt service)
br8  in  1  short relative branch request
br16  in  1  long relative branch request
cond  in  1  branch condition true
mdata  in  16  branch offset / load data
jmp  in  1  absolute jump to jmp_addr
jmp_addr  in  AW  jump target
ld  in  1  load PC from mdata (zero-extended to AW)
pul_en  in  1  write one pulled byte into PC
pul_idx  in  2  byte lane for pul_en, 0 = LSB
vec_go  in  1  start vector fetch
vec_num  in  VW  vector index
vec_addr  out  AW  vector byte address
vec_rd  out  1  vector byte read request
vec_ack  in  1  read data valid
vec_data  in  8  read data
busy  out  1  vector FSM active
taken  out  1  one-cycle pulse: branch applied this cycle
pc  out  AW  program counter

Behaviour:
- Reset: pc=RST_PC, FSM=IDLE, vec_rd=0, vec_addr=0, busy=0, taken=0, branch lock=0. A reset mid-fetch aborts the fetch; no partial PC write.
- Update priority per cen cycle:
  1. Vector FSM DONE
  2. inc && !inc_hold: pc+1
  3. br8 taken: pc + sign-extended mdata[7:0]
  4. br16 taken: pc + sign-extended mdata
  5. jmp: jmp_addr
  6. ld: {0, mdata}
  7. hold
- pul_en is applied after the above in the same cycle. It overwrites byte pul_idx of the result. pul_idx >= AW/8 is ignored.
- All arithmetic is modulo 2^AW; 0xFFFF+1 wraps to 0 at AW=16.
- Branch taken = (br8|br16) && cond && !lock.
- lock sets on any taken branch and clears only when br8 and br16 are both low on a cen cycle. A held request therefore applies exactly once.
- taken pulses for 1 cen cycle per applied branch.
- While busy, inc/br/jmp/ld/pul_en are ignored.
- vec_go while busy is ignored.
- Vector FSM:
  - IDLE: on vec_go, go to RDHI with vec_addr=VEC_BASE+2*vec_num and vec_rd=1.
  - RDHI: on vec_ack, latch hi byte, vec_addr+=1, go to RDLO.
  - RDLO: on vec_ack, latch lo byte, vec_rd=0, go to DONE.
  - DONE: pc={hi,lo} zero-extended to AW; go to IDLE.
  - vec_rd stays high until ack; an ack while vec_rd is low is ignored.
  - busy is high in RDHI, RDLO and DONE.
  - Minimum fetch is 3 cen cycles after vec_go.

Optional Feature:
JTKCPU_BRTRACE_EN.
- Defined: adds outputs br_src[AW-1:0] and br_dst[AW-1:0], both reset to 0. On every taken branch, jmp, ld or vector DONE, they capture the pre-update pc and the new pc.
- Undefined: the ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset, then inc high 3 cycles -> pc=0x0003. Then inc with inc_hold=1 -> pc stays 0x0003.
- pc=0x1000, br8=1 held 4 cycles, cond=1, mdata=0x00F0 -> pc=0x0FF0 once, taken pulses once. br8 low then high again -> pc=0x0FE0.
- pc=0xFFF0, br16, cond=1, mdata=0x0020 -> pc=0x0010 (wrap). Same with cond=0 -> pc unchanged, taken=0.
- vec_go with vec_num=3 -> vec_addr 0xFFF6 then 0xFFF7. With 2-cycle ack delays and data 0x12/0x34 -> pc=0x1234; a concurrent inc is ignored while busy.
- pc=0x5678, pul_en idx1 data 0xAB -> pc=0xAB78. With AW=24: ld mdata=0x1234 -> pc=0x001234, and pul_idx=2 data 0x7F -> pc=0x7F1234.
- Assert rst during RDLO -> pc=RST_PC, busy=0, vec_rd=0. A following vec_go restarts cleanly.
